// File: rtl/adc_reader_pkg.sv
// rtl/adc_reader_pkg.sv - shared FSM states and width helper for the ADC reader
package adc_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Bits needed to hold 0..value-1; never less than one so counters stay legal.
    function automatic int clogb2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/adc_reader_sck_gen.sv
// rtl/adc_reader_sck_gen.sv - spi_sck generator with rise strobe, bit counter and frame-done strobe
module adc_reader_sck_gen
    import adc_reader_pkg::*;
#(
    parameter int FRAME_BITS = 16,
    parameter int SCK_HALF   = 2,
    localparam int BW        = clogb2(FRAME_BITS),
    localparam int HW        = clogb2(SCK_HALF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    output logic          o_sck,
    output logic          o_rise,
    output logic          o_done,
    output logic [BW-1:0] o_bit
);

    localparam logic [HW-1:0] HALF_LAST = HW'(SCK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);

    logic          r_active;
    logic          r_sck;
    logic [HW-1:0] r_half;
    logic [BW-1:0] r_bit;
    logic          w_half_end;

    assign w_half_end = r_active && (r_half == HALF_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_active <= 1'b0;
            r_sck    <= 1'b0;
            r_half   <= '0;
            r_bit    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_sck    <= 1'b0;
            r_half   <= '0;
            r_bit    <= '0;
        end else if (r_active) begin
            if (w_half_end) begin
                r_half <= '0;
                r_sck  <= ~r_sck;
                // A falling sck closes the current bit.
                if (r_sck) begin
                    if (r_bit == BIT_LAST) begin
                        r_active <= 1'b0;
                    end else begin
                        r_bit <= r_bit + 1'b1;
                    end
                end
            end else begin
                r_half <= r_half + 1'b1;
            end
        end
    end

    assign o_sck  = r_sck;
    assign o_rise = w_half_end && !r_sck;
    assign o_done = w_half_end && r_sck && (r_bit == BIT_LAST);
    assign o_bit  = r_bit;

endmodule

// File: rtl/adc_reader.sv
// rtl/adc_reader.sv - SPI master sampling one serial ADC channel every DIV clocks
module adc_reader
    import adc_reader_pkg::*;
#(
    parameter int DIV        = 50000,
    parameter int SIZE       = 12,
    parameter int FRAME_BITS = 16,
    parameter int LEAD       = 2,
    parameter int SCK_HALF   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            spi_miso,
    output logic            spi_sck,
    output logic            ad_conv,
    output logic [SIZE-1:0] data,
    output logic            valid,
    output logic            busy
);

    localparam int CW = clogb2(DIV);
    localparam int BW = clogb2(FRAME_BITS);

    if ((DIV <= 2 + 2 * SCK_HALF * FRAME_BITS) || (LEAD < 0) || (SIZE < 2) ||
        (LEAD + SIZE > FRAME_BITS) || (SCK_HALF < 1)) begin : g_param_check
        $error("adc_reader: DIV, LEAD, SIZE or SCK_HALF out of range");
    end

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [SIZE-1:0] r_shift;
    logic [SIZE-1:0] r_data;
    logic            r_ad_conv;
    logic            r_valid;
    logic            r_busy;

    logic            w_tick;
    logic            w_rise;
    logic            w_done;
    logic [BW-1:0]   w_bit;
    logic [31:0]     w_bit_ext;
    logic            w_in_win;

    assign w_tick    = (r_count == CW'(DIV - 1));
    assign w_bit_ext = 32'(w_bit);
    assign w_in_win  = (w_bit_ext >= LEAD) && (w_bit_ext < LEAD + SIZE);

    adc_reader_sck_gen #(
        .FRAME_BITS(FRAME_BITS),
        .SCK_HALF  (SCK_HALF)
    ) u_sck_gen (
        .clk    (clk),
        .rst    (rst),
        .i_start(r_state == ST_CONV),
        .o_sck  (spi_sck),
        .o_rise (w_rise),
        .o_done (w_done),
        .o_bit  (w_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_ad_conv <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_count   <= w_tick ? '0 : r_count + 1'b1;
            r_ad_conv <= 1'b0;
            r_valid   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state   <= ST_CONV;
                        r_ad_conv <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                ST_CONV: begin
                    r_state <= ST_SHIFT;
                    r_shift <= '0;
                end
                ST_SHIFT: begin
                    // Only the SIZE-bit window after the LEAD bits is kept, MSB first.
                    if (w_rise && w_in_win) begin
                        r_shift <= {r_shift[SIZE-2:0], spi_miso};
                    end
                    if (w_done) begin
                        r_state <= ST_DONE;
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ad_conv = r_ad_conv;
    assign data    = r_data;
    assign valid   = r_valid;
    assign busy    = r_busy;

endmodule
